score_display_mux: RTL and testbench
====================================

# score_display_mux

Parametrised multi-digit 7-segment score display driver for the game's score readout. It captures a binary score on a load strobe and converts it to BCD with a sequential shift-and-add-3 (double-dabble) engine. It then time-multiplexes the digits onto one shared segment bus with active-low digit cathodes. It sits between the game-state logic (score value and change strobe) and the board's common-cathode 7-segment pins.

## Interface
- DIGITS, 3: number of displayed digits, legal range 1..6.
- WIDTH, 10: bit width of the input score, legal range 1..20.
- REFRESH_DIV, 50000: clock cycles each digit stays enabled, minimum 1.
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- change_score  input  1  load strobe; `number` is sampled on any rising edge where this is high.
- number  input  WIDTH  unsigned binary score to display.
- busy  output  1  high while a conversion is in progress.
- cathode  output  DIGITS  one-hot active-low digit enable; bit 0 is the most significant (leftmost) digit.
- segments  output  7  active-high segment pattern, ordered {top, top_right, bot_right, bot, bot_left, top_left, middle}.

## Operation
- **Reset values:** `busy`=0; `cathode`=all ones (all digits off); `segments`=7'b0000000; displayed digit register = all zero; scan index = 0; prescaler = 0; FSM = IDLE.
- **FSM states:**
  - IDLE: on `change_score`=1, go to SHIFT.
  - SHIFT: runs exactly WIDTH cycles, then goes to COMMIT.
  - COMMIT: runs 1 cycle, then returns to IDLE.
- **Load:**
  - Loading happens on the `change_score` edge in any state.
  - Before loading, `number` is saturated to MAXV = 10^DIGITS − 1. Values above MAXV load MAXV; for example, DIGITS=3 with number=1023 displays 999.
  - The load clears a 4·DIGITS-bit BCD accumulator and the bit counter.
- **SHIFT cycle:** every BCD nibble ≥ 5 gets +3 added, then {BCD, binary} is shifted left by 1 bit.
- **COMMIT:** the accumulator is copied atomically into the displayed digit register. The displayed value never shows a partial conversion.
- **Restart:** `change_score` during SHIFT or COMMIT aborts the current conversion and restarts with the new `number` (last load wins). A COMMIT that is aborted this way does not update the display.
- **Scan:**
  - The prescaler counts 0..REFRESH_DIV−1. On wrap, the scan index advances 0→1→…→DIGITS−1→0.
  - Every cycle, `cathode` and `segments` are registered from the current scan index and displayed digit. Only the selected bit of `cathode` is low.
- **Decode:** 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Any other nibble decodes to 0000000.
- **Independence:** conversion does not stall the scan. The scan keeps showing the old value until COMMIT.

## Timing
- **Conversion latency:**
  - The load edge is edge t.
  - `busy`=1 from after edge t through edge t+WIDTH+1.
  - The displayed register updates at edge t+WIDTH+1.
  - `busy` returns to 0 after that edge, unless a new load occurred.
- **Display pipeline:** the new value appears on `segments` one cycle after the display register updates, when its digit is selected.
- **First scan output:** the first rising edge after reset deassertion drives `cathode` with only bit 0 low and `segments` for digit 0.
- **Digit dwell:** each digit is held REFRESH_DIV cycles. A full frame is DIGITS·REFRESH_DIV cycles.
- **Edge alignment:** `cathode` and `segments` change on the same edge.
- **Reset mid-conversion:** the conversion is abandoned with no commit. All outputs immediately take their reset values.
- **DIGITS=1:** the scan index stays at 0, and `cathode`=1'b0 permanently after the first post-reset edge.

## Configuration
- **Macro:** `SEG_LZ_BLANK_EN`.
- **Defined:** leading-zero blanking is on. Every zero digit to the left of the first non-zero digit outputs `segments`=0000000 while its cathode is still scanned. The least significant digit is never blanked, so a value of 0 shows a single "0".
- **Undefined:** all digits are shown, including leading zeros; for example, 7 displays as 007.

## Test plan
- **Reset (DIGITS=3, REFRESH_DIV=4):**
  - Stimulus: assert `reset` mid-scan.
  - Response: `cathode`=3'b111, `segments`=0, `busy`=0 immediately.
  - Stimulus: release `reset`.
  - Response: after the next edge, `cathode`=3'b110 and `segments`=1111110.
- **Basic conversion (DIGITS=3, WIDTH=10):**
  - Stimulus: pulse `change_score` with number=347.
  - Response: `busy` high for 11 cycles.
  - Response: the scan then yields 1111001 (cathode 110), 0110011 (cathode 101), 1110000 (cathode 011), each for REFRESH_DIV cycles, then wraps.
- **Saturation:**
  - Stimulus: load number=1023.
  - Response: all three digits show 1111011 (999).
- **Leading zeros:**
  - Stimulus: load number=7.
  - Response with `SEG_LZ_BLANK_EN`: digits 0 and 1 output 0000000, and digit 2 outputs 1110000.
  - Response without it: 1111110, 1111110, 1110000.
- **Restart:**
  - Stimulus: load 123, then load 456 five cycles later.
  - Response: 123 is never displayed, `busy` stays high continuously, and 456 commits 11 cycles after the second load.
- **Reset mid-conversion:**
  - Stimulus: with 500 displayed, load 999 and assert `reset` at cycle 4.
  - Response: after release, all digits display 0 and `busy`=0.

Source files
------------

// File: rtl/score_display_mux.sv
// Multi-digit 7-segment score driver: saturating load, sequential double-dabble BCD
// conversion, and a time-multiplexed digit scan. Define SEG_LZ_BLANK_EN for leading-zero blanking.
module score_display_mux #(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              change_score,
  input  logic [WIDTH-1:0]  number,
  output logic              busy,
  output logic [DIGITS-1:0] cathode,
  output logic [6:0]        segments
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned MAXV  = 10 ** DIGITS - 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  adj;
  logic [WIDTH-1:0]  sat;
  logic              busy_d;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        nib;
  logic [DIGITS-1:0] cath_d;
  logic [6:0]        seg_d;
`ifdef SEG_LZ_BLANK_EN
  logic              lead_zero;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Clamp to the largest value the digits can show.
  always_comb begin
    sat = number;
    if (32'(number) > MAXV) sat = WIDTH'(MAXV);
  end

  // Conversion FSM; a load strobe in any state restarts and suppresses a pending commit.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    adj     = bcd_q;
    if (change_score) begin
      state_d = ST_SHIFT;
      bin_d   = sat;
      bcd_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
          end
          {bcd_d, bin_d} = {adj, bin_q} << 1;
          cnt_d = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_d  = bcd_q;
          state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Scan prescaler/index and the next cathode/segment pattern.
  always_comb begin
    pre_d = PRE_W'(pre_q + 1'b1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : IDX_W'(idx_q + 1'b1);
    end
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) nib = disp_q[4*(DIGITS-1-i) +: 4];
    end
    cath_d = ~(DIGITS'(1) << idx_q);
    seg_d  = seg_decode(nib);
`ifdef SEG_LZ_BLANK_EN
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) <= idx_q && disp_q[4*(DIGITS-1-i) +: 4] != 4'd0) lead_zero = 1'b0;
    end
    if (lead_zero && idx_q != IDX_W'(DIGITS - 1)) seg_d = 7'b0000000;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      disp_q   <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      cathode  <= '1;
      segments <= 7'b0000000;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      disp_q   <= disp_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      cathode  <= cath_d;
      segments <= seg_d;
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux: decimal reference model of the shown value and scan position.
module tb_score_display_mux;

  localparam int unsigned DIGITS      = 3;
  localparam int unsigned WIDTH       = 10;
  localparam int unsigned REFRESH_DIV = 4;
  localparam int          MAXV        = 999;

  logic              clock;
  logic              reset;
  logic              change_score;
  logic [WIDTH-1:0]  number;
  logic              busy;
  logic [DIGITS-1:0] cathode;
  logic [6:0]        segments;

  int tests = 0;
  int fails = 0;
  int ecnt;
  int shown = 0;

  score_display_mux #(.DIGITS(DIGITS), .WIDTH(WIDTH), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clock(clock), .reset(reset), .change_score(change_score), .number(number),
    .busy(busy), .cathode(cathode), .segments(segments)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edges since reset release; edge 1 shows digit 0.
  always @(posedge clock or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx);
    int p;
    p = pow10(int'(DIGITS) - 1 - idx);
`ifdef SEG_LZ_BLANK_EN
    if (idx != int'(DIGITS) - 1 && v < p) return 7'b0000000;
`endif
    return dec((v / p) % 10);
  endfunction

  function automatic int cur_idx();
    return ((ecnt - 1) / int'(REFRESH_DIV)) % int'(DIGITS);
  endfunction

  function automatic logic [DIGITS-1:0] exp_cath(input int idx);
    return ~(DIGITS'(1) << idx);
  endfunction

  function automatic int clamp(input int n);
    return (n > MAXV) ? MAXV : n;
  endfunction

  // Drives a one-cycle load strobe; returns at the falling edge after the load edge.
  task automatic pulse_load(input int n);
    @(negedge clock);
    change_score = 1'b1;
    number       = WIDTH'(n);
    @(negedge clock);
    change_score = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; change_score = 1'b0; number = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    #1;
    tests++;
    if (cathode !== 3'b111 || segments !== 7'b0000000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals got cath=%b seg=%b busy=%b exp cath=111 seg=0000000 busy=0", cathode, segments, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (cathode !== exp_cath(0) || segments !== exp_seg(0, 0)) begin
      fails++;
      $display("FAIL first_scan got cath=%b seg=%b exp cath=%b seg=%b", cathode, segments, exp_cath(0), exp_seg(0, 0));
    end
    shown = 0;
  endtask

  task automatic test_basic();
    @(negedge clock);
    change_score = 1'b1;
    number       = WIDTH'(347);
    @(negedge clock);
    change_score = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clock);
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_high cyc=%0d got %b exp 1", c, busy);
      end
    end
    @(negedge clock);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_drop got %b exp 0", busy);
    end
    shown = 347;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      tests++;
      if (cathode !== exp_cath(cur_idx()) || segments !== exp_seg(shown, cur_idx())) begin
        fails++;
        $display("FAIL basic_scan got cath=%b seg=%b exp cath=%b seg=%b", cathode, segments,
                 exp_cath(cur_idx()), exp_seg(shown, cur_idx()));
      end
    end
  endtask

  task automatic test_values(input string name, input int vals[$]);
    foreach (vals[j]) begin
      pulse_load(vals[j]);
      repeat (11) @(negedge clock);
      shown = clamp(vals[j]);
      for (int k = 0; k < 12; k++) begin
        @(negedge clock);
        tests++;
        if (cathode !== exp_cath(cur_idx()) || segments !== exp_seg(shown, cur_idx()) || busy !== 1'b0) begin
          fails++;
          $display("FAIL %s n=%0d got cath=%b seg=%b busy=%b exp cath=%b seg=%b busy=0", name, vals[j],
                   cathode, segments, busy, exp_cath(cur_idx()), exp_seg(shown, cur_idx()));
        end
      end
    end
  endtask

  task automatic test_restart();
    int old_v;
    old_v = shown;
    @(negedge clock);
    change_score = 1'b1;
    number       = WIDTH'(123);
    for (int c = 1; c <= 30; c++) begin
      int e, v;
      @(negedge clock);
      e = c - 1;
      v = (e >= 17) ? 456 : old_v;
      tests++;
      if (busy !== ((e <= 15) ? 1'b1 : 1'b0) || segments !== exp_seg(v, cur_idx())) begin
        fails++;
        $display("FAIL restart e=%0d got busy=%b seg=%b exp busy=%b seg=%b", e, busy, segments,
                 (e <= 15), exp_seg(v, cur_idx()));
      end
      if (c == 1) change_score = 1'b0;
      if (c == 5) begin
        change_score = 1'b1;
        number       = WIDTH'(456);
      end
      if (c == 6) change_score = 1'b0;
    end
    shown = 456;
  endtask

  task automatic test_reset_mid();
    pulse_load(500);
    repeat (14) @(negedge clock);
    pulse_load(999);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    tests++;
    if (cathode !== 3'b111 || segments !== 7'b0000000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_vals got cath=%b seg=%b busy=%b exp cath=111 seg=0000000 busy=0", cathode, segments, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    shown = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      tests++;
      if (cathode !== exp_cath(cur_idx()) || segments !== exp_seg(0, cur_idx()) || busy !== 1'b0) begin
        fails++;
        $display("FAIL midreset_scan got cath=%b seg=%b busy=%b exp cath=%b seg=%b busy=0", cathode, segments,
                 busy, exp_cath(cur_idx()), exp_seg(0, cur_idx()));
      end
    end
  endtask

  initial begin
    int rnd[$];
    test_reset();
    test_basic();
    test_values("saturate", '{1023, 1000, 999, int'($urandom_range(1000, 1023))});
    test_values("leading", '{7, 0, 40, 5, 100});
    for (int i = 0; i < 6; i++) rnd.push_back(int'($urandom_range(0, 1023)));
    test_values("random", rnd);
    test_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
